dma_axi_rd_if: RTL and testbench

AXI4 read-channel front end of the DMA. It accepts burst requests from the read-side streamer (addr/alen/size/strb/valid with a ready return) and issues them on the AR channel. It tracks up to `MAX_OUTSTANDING` in-flight bursts, checks returning R beats against the expected length, and buffers data into an output FIFO feeding the write-side datapath. Protocol errors are reported through a sticky error port toward the DMA FSM.

---
 rtl/dma_axi_rd_if_if.sv | 53 +++++
 rtl/dma_axi_rd_if.sv | 132 +++++++++++++
 tb/tb_dma_axi_rd_if.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_axi_rd_if_if.sv
// rtl/dma_axi_rd_if_if.sv - request, AXI AR/R and output stream bundle for the DMA read front end
interface dma_axi_rd_if_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 512
);
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [7:0]              req_alen;
  logic [2:0]              req_size;
  logic [DATA_WIDTH/8-1:0] req_strb;
  logic                    req_valid;
  logic                    req_ready;

  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;

  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  logic [DATA_WIDTH-1:0]   out_data;
  logic [DATA_WIDTH/8-1:0] out_strb;
  logic                    out_last;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    input  req_addr, req_alen, req_size, req_strb, req_valid,
    output req_ready,
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready,
    output out_data, out_strb, out_last, out_valid,
    input  out_ready
  );

  modport slave (
    output req_addr, req_alen, req_size, req_strb, req_valid,
    input  req_ready,
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready,
    input  out_data, out_strb, out_last, out_valid,
    output out_ready
  );
endinterface

// File: rtl/dma_axi_rd_if.sv
// rtl/dma_axi_rd_if.sv - AXI4 read-channel front end: AR issue, burst tracking, length check, output FIFO
module dma_axi_rd_if #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 512,
  parameter int MAX_OUTSTANDING = 4,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  dma_axi_rd_if_if.master       bus,
  input  logic                  err_clr,
  output logic                  err_valid,
  output logic [1:0]            err_src,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  idle
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int TW = $clog2(MAX_OUTSTANDING);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam logic [TW:0] MAX_OUT = (TW+1)'(MAX_OUTSTANDING);

  logic [TW:0]           outstanding;
  logic [TW:0]           trk_wr, trk_rd;
  logic [ADDR_WIDTH-1:0] trk_addr [MAX_OUTSTANDING];
  logic [7:0]            trk_alen [MAX_OUTSTANDING];
  logic [SW-1:0]         trk_strb [MAX_OUTSTANDING];
  logic [7:0]            beat_cnt;

  logic [FW:0]           fifo_wr, fifo_rd;
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [SW-1:0]         fifo_strb [FIFO_DEPTH];
  logic                  fifo_last [FIFO_DEPTH];

  logic                  accept, r_hs, pop, trk_empty, last_beat, trk_pop;
  logic                  fifo_full, fifo_empty, resp_err, len_err, new_err;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [7:0]            head_alen;
  logic [SW-1:0]         head_strb;

  assign bus.req_ready = (~bus.arvalid || bus.arready) && (outstanding < MAX_OUT);
  assign bus.arburst   = 2'b01;
  assign accept        = bus.req_valid && bus.req_ready;
  assign r_hs          = bus.rvalid && bus.rready;
  assign pop           = bus.out_valid && bus.out_ready;

  assign trk_empty = (trk_wr == trk_rd);
  assign head_addr = trk_addr[trk_rd[TW-1:0]];
  assign head_alen = trk_alen[trk_rd[TW-1:0]];
  assign head_strb = trk_strb[trk_rd[TW-1:0]];
  assign last_beat = (beat_cnt == head_alen);
  // The burst always ends at the tracked length, whatever rlast says, so the tags stay aligned.
  assign trk_pop   = r_hs && ~trk_empty && last_beat;

  assign fifo_empty = (fifo_wr == fifo_rd);
  assign fifo_full  = (fifo_wr[FW] != fifo_rd[FW]) && (fifo_wr[FW-1:0] == fifo_rd[FW-1:0]);
  assign bus.rready = ~fifo_full;

  assign bus.out_valid = ~fifo_empty;
  assign bus.out_data  = fifo_empty ? '0 : fifo_data[fifo_rd[FW-1:0]];
  assign bus.out_strb  = fifo_empty ? '0 : fifo_strb[fifo_rd[FW-1:0]];
  assign bus.out_last  = fifo_empty ? 1'b0 : fifo_last[fifo_rd[FW-1:0]];

  assign idle = ~bus.arvalid && (outstanding == '0) && fifo_empty;

  assign resp_err = r_hs && bus.rresp[1];
  assign len_err  = r_hs && ~trk_empty && (bus.rlast != last_beat);
  assign new_err  = resp_err || len_err;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.arvalid <= 1'b0;
      bus.araddr  <= '0;
      bus.arlen   <= '0;
      bus.arsize  <= '0;
      outstanding <= '0;
      trk_wr      <= '0;
      trk_rd      <= '0;
      beat_cnt    <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      err_valid   <= 1'b0;
      err_src     <= '0;
      err_addr    <= '0;
    end else begin
      if (accept) begin
        bus.arvalid <= 1'b1;
        bus.araddr  <= bus.req_addr;
        bus.arlen   <= bus.req_alen;
        bus.arsize  <= bus.req_size;
      end else if (bus.arready) begin
        bus.arvalid <= 1'b0;
      end

      case ({accept, r_hs && bus.rlast && (outstanding != '0)})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase

      if (accept)  trk_wr <= trk_wr + 1'b1;
      if (trk_pop) trk_rd <= trk_rd + 1'b1;
      if (r_hs && ~trk_empty) beat_cnt <= last_beat ? 8'd0 : beat_cnt + 8'd1;

      if (r_hs) fifo_wr <= fifo_wr + 1'b1;
      if (pop)  fifo_rd <= fifo_rd + 1'b1;

      // A clear in the same cycle as a fresh error yields to the fresh error.
      if (new_err && (!err_valid || err_clr)) begin
        err_valid <= 1'b1;
        err_src   <= resp_err ? 2'd1 : 2'd2;
        err_addr  <= head_addr;
      end else if (err_clr) begin
        err_valid <= 1'b0;
        err_src   <= '0;
        err_addr  <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      trk_addr[trk_wr[TW-1:0]] <= bus.req_addr;
      trk_alen[trk_wr[TW-1:0]] <= bus.req_alen;
      trk_strb[trk_wr[TW-1:0]] <= (bus.req_alen == 8'd0) ? bus.req_strb : '1;
    end
    if (r_hs) begin
      fifo_data[fifo_wr[FW-1:0]] <= bus.rdata;
      fifo_strb[fifo_wr[FW-1:0]] <= head_strb;
      fifo_last[fifo_wr[FW-1:0]] <= last_beat;
    end
  end
endmodule

// File: tb/tb_dma_axi_rd_if.sv
// tb/tb_dma_axi_rd_if.sv - directed scoreboard bench for dma_axi_rd_if
module tb_dma_axi_rd_if;
  localparam int AW = 32;
  localparam int DW = 512;
  localparam int SW = DW / 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } ar_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          err_clr;
  logic          err_valid;
  logic [1:0]    err_src;
  logic [AW-1:0] err_addr;
  logic          idle;

  int    tests = 0;
  int    fails = 0;
  beat_t sb [$];
  ar_t   ar_q [$];
  beat_t mon_b;
  ar_t   mon_a;

  always #5 clk = ~clk;

  dma_axi_rd_if_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dma_axi_rd_if #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(4), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .err_clr(err_clr),
    .err_valid(err_valid), .err_src(err_src), .err_addr(err_addr), .idle(idle)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  always @(negedge clk) begin
    if (rstn && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("out_extra", sb.size(), 1);
      end else begin
        mon_b = sb.pop_front();
        check("out_data", bus.out_data, mon_b.data);
        check("out_strb", bus.out_strb, mon_b.strb);
        check("out_last", bus.out_last, mon_b.last);
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && bus.arvalid && bus.arready) begin
      if (ar_q.size() == 0) begin
        check("ar_extra", ar_q.size(), 1);
      end else begin
        mon_a = ar_q.pop_front();
        check("araddr", bus.araddr, mon_a.addr);
        check("arlen", bus.arlen, mon_a.len);
      end
    end
  end

  task automatic send_req(input logic [AW-1:0] a, input logic [7:0] len, input logic [SW-1:0] s);
    int n = 0;
    bus.req_addr  = a;
    bus.req_alen  = len;
    bus.req_size  = 3'd6;
    bus.req_strb  = s;
    bus.req_valid = 1'b1;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("req_accept", bus.req_ready, 1);
    ar_q.push_back('{a, len});
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic r_beat(input logic [DW-1:0] d, input logic [1:0] resp, input logic last,
                        input logic [SW-1:0] es, input logic el);
    int n = 0;
    bus.rdata  = d;
    bus.rresp  = resp;
    bus.rlast  = last;
    bus.rvalid = 1'b1;
    @(negedge clk);
    while (!bus.rready && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("r_accept", bus.rready, 1);
    sb.push_back('{d, es, el});
    @(posedge clk);
    #1;
  endtask

  task automatic burst(input int nb, input logic [SW-1:0] es, input int last_at, input int err_at);
    for (int i = 0; i < nb; i++)
      r_beat(rnd_data(), (i == err_at) ? 2'b10 : 2'b00, i == last_at, es, i == nb - 1);
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    bus.rresp  = 2'b00;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!idle && n < 500) begin
      n++;
      @(negedge clk);
    end
    check("idle", idle, 1);
    check("sb_drained", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("err_cleared", err_valid, 0);
    check("err_src_cleared", err_src, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end

  initial begin
    bus.req_addr = '0; bus.req_alen = '0; bus.req_size = '0; bus.req_strb = '0;
    bus.req_valid = 1'b0; bus.arready = 1'b1;
    bus.rdata = '0; bus.rresp = '0; bus.rlast = 1'b0; bus.rvalid = 1'b0;
    bus.out_ready = 1'b1; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    @(negedge clk);
    check("rst_idle", idle, 1);
    check("rst_arvalid", bus.arvalid, 0);
    check("rst_arburst", bus.arburst, 2'b01);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_rready", bus.rready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_err_valid", err_valid, 0);
    @(posedge clk);
    #1;

    // single 4-beat burst
    send_req(32'h1000, 8'd3, '1);
    check("t1_arvalid", bus.arvalid, 1);
    check("t1_araddr", bus.araddr, 32'h1000);
    check("t1_arlen", bus.arlen, 3);
    burst(4, '1, 3, -1);
    wait_idle();

    // narrow single beat
    send_req(32'h1040, 8'd0, 64'h00FF);
    burst(1, 64'h00FF, 0, -1);
    wait_idle();

    // outstanding limit with AR backpressure
    bus.arready = 1'b0;
    send_req(32'h5000, 8'd0, 64'h1);
    bus.req_addr  = 32'h5040;
    bus.req_valid = 1'b1;
    @(negedge clk);
    check("t3_req_ready_held", bus.req_ready, 0);
    check("t3_arvalid_held", bus.arvalid, 1);
    check("t3_araddr_held", bus.araddr, 32'h5000);
    @(posedge clk);
    #1 bus.arready = 1'b1;
    for (int i = 1; i < 4; i++) send_req(32'h5000 + 32'(i * 64), 8'd0, SW'(1) << i);
    bus.req_addr  = 32'h5100;
    bus.req_strb  = SW'(1) << 4;
    bus.req_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("t3_req_ready_full", bus.req_ready, 0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    burst(1, SW'(1), 0, -1);
    check("t3_req_ready_freed", bus.req_ready, 1);
    send_req(32'h5100, 8'd0, SW'(1) << 4);
    for (int i = 1; i < 5; i++) burst(1, SW'(1) << i, 0, -1);
    wait_idle();

    // SLVERR on beat 2
    send_req(32'h2000, 8'd3, '1);
    burst(4, '1, 3, 1);
    check("t4_err_valid", err_valid, 1);
    check("t4_err_src", err_src, 1);
    check("t4_err_addr", err_addr, 32'h2000);
    wait_idle();
    pulse_clr();

    // early rlast, followed by a narrow burst that must keep its own tag
    send_req(32'h3000, 8'd3, '1);
    send_req(32'h3040, 8'd0, 64'h0F0F);
    burst(4, '1, 1, -1);
    check("t5_err_valid", err_valid, 1);
    check("t5_err_src", err_src, 2);
    check("t5_err_addr", err_addr, 32'h3000);
    burst(1, 64'h0F0F, 0, -1);
    check("t5_err_addr_kept", err_addr, 32'h3000);
    wait_idle();
    pulse_clr();

    // output FIFO fills and back-pressures R
    bus.out_ready = 1'b0;
    send_req(32'h4000, 8'd19, '1);
    for (int i = 0; i < 16; i++) r_beat(rnd_data(), 2'b00, 1'b0, '1, 1'b0);
    bus.rdata = rnd_data();
    @(negedge clk);
    check("t6_rready_full", bus.rready, 0);
    check("t6_out_valid", bus.out_valid, 1);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    for (int i = 16; i < 20; i++) r_beat(rnd_data(), 2'b00, i == 19, '1, i == 19);
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    wait_idle();
    check("t6_no_err", err_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
